id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the MIPS core.
- Sits directly upstream of ALU_32bit and drives its Src1, Src2 and ALU_Control inputs.
- Captures decoded operands and controls each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Holds, or inserts a bubble, on the Stall and Flush commands.

Parameters:
- WIDTH, 32, datapath width.
- REG_AW, 5, register-address width.
- CTRL_W, 3, ALU_Control width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  hold the EX contents this cycle.
- Flush  in  1  replace the captured instruction with a bubble.
- ID_Valid  in  1  decode slot holds a real instruction.
- ID_RD1  in  WIDTH  register-file read data for rs.
- ID_RD2  in  WIDTH  register-file read data for rt.
- ID_SignImm  in  WIDTH  sign-extended immediate.
- ID_Rs, ID_Rt, ID_Rd  in  REG_AW  source and destination register numbers.
- ID_ALU_Control  in  CTRL_W  ALU operation code.
- ID_ALUSrc  in  1  1 = Src2 takes the immediate.
- ID_RegDst  in  1  1 = destination is Rd, 0 = Rt.
- ID_RegWrite  in  1  instruction writes the register file.
- MEM_RegWrite  in  1  EX/MEM write enable.
- MEM_WriteReg  in  REG_AW  EX/MEM destination register.
- MEM_ALU_Result  in  WIDTH  EX/MEM result.
- WB_RegWrite  in  1  MEM/WB write enable.
- WB_WriteReg  in  REG_AW  MEM/WB destination register.
- WB_Result  in  WIDTH  MEM/WB result.
- Src1  out  WIDTH  ALU operand A.
- Src2  out  WIDTH  ALU operand B.
- ALU_Control  out  CTRL_W  ALU operation code.
- EX_WriteData  out  WIDTH  forwarded rt value, used as store data.
- EX_WriteReg  out  REG_AW  resolved destination register.
- EX_RegWrite  out  1  write enable, qualified by valid.
- EX_Valid  out  1  EX slot holds a real instruction.
- Fwd_A, Fwd_B  out  2  forward selects: 00 register, 01 WB, 10 MEM.

Behaviour:
- Reset:
  - Applied at the clk edge while rst=1.
  - All registers go to 0, except ALU_Control = 3'b111, the ALU no-op whose result is 0.
  - After reset: EX_Valid=0, EX_RegWrite=0, Src1=Src2=0, Fwd_A=Fwd_B=00.
- Update priority per edge: rst > Flush > Stall > load.
- Load (no Stall, no Flush):
  - Register all ID_* fields.
  - EX_WriteReg <= ID_RegDst ? ID_Rd : ID_Rt.
  - EX_RegWrite <= ID_RegWrite & ID_Valid.
  - EX_Valid <= ID_Valid.
  - Latency: one cycle from ID inputs to the outputs.
- Flush:
  - Valid, RegWrite and the forward state clear.
  - ALU_Control goes to 3'b111; data fields go to 0.
  - Flush overrides Stall in the same cycle.
- Stall, with operand refresh:
  - Control fields hold.
  - The stored rs and rt data registers load their currently forwarded values, and the stored forward state clears.
  - A producer that retires during a multi-cycle stall therefore cannot lose its value.
  - Src1, Src2 and EX_WriteData stay stable across the whole stall.
- Forwarding: combinational, from the registered Rs and Rt.
  - A = 10 when MEM_RegWrite, MEM_WriteReg != 0 and MEM_WriteReg == Rs.
  - Otherwise A = 01 when the same conditions hold for WB.
  - Otherwise A = 00. B is identical using Rt.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
  - Forwarding applies only when EX_Valid=1; otherwise the select is 00.
- Outputs:
  - Src1 = forwarded rs value.
  - EX_WriteData = forwarded rt value.
  - Src2 = ALUSrc ? SignImm : forwarded rt value.
  - ALU_Control is registered; there is no combinational path from ID_* to any output.
- Width rules: WIDTH-bit passthrough only; no arithmetic is performed in this block.
- Bubbles: ID_Valid=0 loads as a bubble identical to Flush.

Decomposition:
- Shared package holds:
  - ALU op constants: AND=000, OR=001, ADD=010, SUB=100, MUL=101, SLT=110, NOP=111.
  - Forward-select constants: FWD_REG=00, FWD_WB=01, FWD_MEM=10.
  - The WIDTH, REG_AW and CTRL_W defaults.
- One sub-module, forward_unit: a combinational comparator that produces Fwd_A and Fwd_B.
- The pipeline register and muxes stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles → EX_Valid=0, ALU_Control=3'b111, Src1=0, Src2=0.
- Plain load:
  - Stimulus: ID_RD1=10, ID_RD2=15, ALUSrc=0, ALU_Control=010, Valid=1, no hazards.
  - Next cycle → Src1=10, Src2=15, ALU_Control=010, Fwd_A=Fwd_B=00.
  - Repeat with ALUSrc=1, SignImm=32'hFFFFFFFE → Src2=32'hFFFFFFFE.
- Forward priority:
  - Stimulus: EX Rs=8; MEM_WriteReg=8, MEM_ALU_Result=25; WB_WriteReg=8, WB_Result=7; both RegWrite=1.
  - Response: Fwd_A=10, Src1=25.
  - Drop MEM_RegWrite → Fwd_A=01, Src1=7.
  - Set Rs=0 with the writers targeting register 0 → Fwd_A=00, Src1=ID_RD1 value.
- Stall refresh:
  - Stimulus: Rt=9 forwarded from MEM with value 5; assert Stall for 3 cycles; the MEM then WB producer moves on (RegWrite drops).
  - Response: Src2=5 on all stall cycles, Fwd_B=00 from the second cycle.
  - Release → next instruction loads.
- Flush vs Stall: Flush=1 and Stall=1 in the same cycle → next cycle EX_Valid=0, EX_RegWrite=0, ALU_Control=3'b111.
- Reset mid-stall: Stall=1 with a valid instruction, then rst=1 for one cycle → all outputs at reset values; the held instruction is discarded.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: ALU op codes, forward selects
// and the default datapath geometry.
package id_ex_operand_stage_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CTRL_W_DEF = 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b100,
    ALU_MUL = 3'b101,
    ALU_SLT = 3'b110,
    ALU_NOP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// Combinational RAW-hazard comparator: picks MEM over WB over the register
// file for each EX source register. Register 0 is never forwarded.
module forward_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              i_enable,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_writereg,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_writereg,
  output fwd_sel_e          o_fwd_a,
  output fwd_sel_e          o_fwd_b
);

  logic w_mem_live;
  logic w_wb_live;

  assign w_mem_live = i_enable && i_mem_regwrite && (i_mem_writereg != '0);
  assign w_wb_live  = i_enable && i_wb_regwrite  && (i_wb_writereg  != '0);

  // Per-operand priority select, MEM result is the younger producer
  always_comb begin
    o_fwd_a = FWD_REG;
    o_fwd_b = FWD_REG;
    if (w_mem_live && (i_mem_writereg == i_rs))     o_fwd_a = FWD_MEM;
    else if (w_wb_live && (i_wb_writereg == i_rs))  o_fwd_a = FWD_WB;
    if (w_mem_live && (i_mem_writereg == i_rt))     o_fwd_b = FWD_MEM;
    else if (w_wb_live && (i_wb_writereg == i_rt))  o_fwd_b = FWD_WB;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding. Feeds ALU_32bit with
// Src1/Src2/ALU_Control; honours Flush (bubble) and Stall (hold with operand
// refresh so a producer retiring mid-stall is not lost).
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [WIDTH-1:0]  ID_RD1,
  input  logic [WIDTH-1:0]  ID_RD2,
  input  logic [WIDTH-1:0]  ID_SignImm,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic [CTRL_W-1:0] ID_ALU_Control,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_WriteReg,
  input  logic [WIDTH-1:0]  MEM_ALU_Result,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_WriteReg,
  input  logic [WIDTH-1:0]  WB_Result,
  output logic [WIDTH-1:0]  Src1,
  output logic [WIDTH-1:0]  Src2,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic [WIDTH-1:0]  EX_WriteData,
  output logic [REG_AW-1:0] EX_WriteReg,
  output logic              EX_RegWrite,
  output logic              EX_Valid,
  output logic [1:0]        Fwd_A,
  output logic [1:0]        Fwd_B
);

  localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(ALU_NOP);

  logic              r_valid;
  logic              r_regwrite;
  logic              r_alusrc;
  logic              r_fwd_en;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_write_reg;
  logic [WIDTH-1:0]  r_rd1;
  logic [WIDTH-1:0]  r_rd2;
  logic [WIDTH-1:0]  r_imm;

  fwd_sel_e          w_fwd_a;
  fwd_sel_e          w_fwd_b;
  logic [WIDTH-1:0]  w_rs_val;
  logic [WIDTH-1:0]  w_rt_val;

  forward_unit #(.REG_AW(REG_AW)) u_forward_unit (
    .i_enable       (r_valid && r_fwd_en),
    .i_rs           (r_rs),
    .i_rt           (r_rt),
    .i_mem_regwrite (MEM_RegWrite),
    .i_mem_writereg (MEM_WriteReg),
    .i_wb_regwrite  (WB_RegWrite),
    .i_wb_writereg  (WB_WriteReg),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  // Operand muxes: forwarded value or the stored register-file data
  always_comb begin
    unique case (w_fwd_a)
      FWD_MEM: w_rs_val = MEM_ALU_Result;
      FWD_WB:  w_rs_val = WB_Result;
      default: w_rs_val = r_rd1;
    endcase
    unique case (w_fwd_b)
      FWD_MEM: w_rt_val = MEM_ALU_Result;
      FWD_WB:  w_rt_val = WB_Result;
      default: w_rt_val = r_rd2;
    endcase
  end

  // Pipeline register: rst > Flush > Stall > load; ID_Valid=0 loads a bubble.
  // On Stall the forwarded operands are written back into r_rd1/r_rd2 and
  // forwarding is disabled, so the operands stay frozen even after the
  // producer leaves MEM/WB.
  always_ff @(posedge clk) begin
    if (rst || Flush || (!Stall && !ID_Valid)) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_fwd_en    <= 1'b0;
      r_alu_ctrl  <= CTRL_NOP;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
    end else if (Stall) begin
      r_rd1    <= w_rs_val;
      r_rd2    <= w_rt_val;
      r_fwd_en <= 1'b0;
    end else begin
      r_valid     <= 1'b1;
      r_regwrite  <= ID_RegWrite;
      r_alusrc    <= ID_ALUSrc;
      r_fwd_en    <= 1'b1;
      r_alu_ctrl  <= ID_ALU_Control;
      r_rs        <= ID_Rs;
      r_rt        <= ID_Rt;
      r_write_reg <= ID_RegDst ? ID_Rd : ID_Rt;
      r_rd1       <= ID_RD1;
      r_rd2       <= ID_RD2;
      r_imm       <= ID_SignImm;
    end
  end

  assign Src1         = w_rs_val;
  assign Src2         = r_alusrc ? r_imm : w_rt_val;
  assign EX_WriteData = w_rt_val;
  assign ALU_Control  = r_alu_ctrl;
  assign EX_WriteReg  = r_write_reg;
  assign EX_RegWrite  = r_regwrite && r_valid;
  assign EX_Valid     = r_valid;
  assign Fwd_A        = w_fwd_a;
  assign Fwd_B        = w_fwd_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, load, immediate select,
// forward priority, stall refresh, flush-over-stall and reset mid-stall.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, ID_Valid;
  logic [31:0] ID_RD1, ID_RD2, ID_SignImm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [2:0]  ID_ALU_Control;
  logic        ID_ALUSrc, ID_RegDst, ID_RegWrite;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_WriteReg, WB_WriteReg;
  logic [31:0] MEM_ALU_Result, WB_Result;
  logic [31:0] Src1, Src2, EX_WriteData;
  logic [2:0]  ALU_Control;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_Valid;
  logic [1:0]  Fwd_A, Fwd_B;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  id_ex_operand_stage #(.WIDTH(32), .REG_AW(5), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_SignImm(ID_SignImm),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ALU_Control(ID_ALU_Control), .ID_ALUSrc(ID_ALUSrc),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .MEM_ALU_Result(MEM_ALU_Result), .WB_RegWrite(WB_RegWrite),
    .WB_WriteReg(WB_WriteReg), .WB_Result(WB_Result),
    .Src1(Src1), .Src2(Src2), .ALU_Control(ALU_Control),
    .EX_WriteData(EX_WriteData), .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_Valid(EX_Valid),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0; ID_Valid = 1'b0;
    ID_RD1 = '0; ID_RD2 = '0; ID_SignImm = '0;
    ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;
    ID_ALU_Control = 3'b000; ID_ALUSrc = 1'b0; ID_RegDst = 1'b0; ID_RegWrite = 1'b0;
    MEM_RegWrite = 1'b0; MEM_WriteReg = '0; MEM_ALU_Result = '0;
    WB_RegWrite = 1'b0; WB_WriteReg = '0; WB_Result = '0;

    // Reset for two cycles
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(EX_Valid), 32'd0);
    check("rst_regwrite", 32'(EX_RegWrite), 32'd0);
    check("rst_ctrl", 32'(ALU_Control), 32'h7);
    check("rst_src1", Src1, 32'd0);
    check("rst_src2", Src2, 32'd0);
    check("rst_fwd_a", 32'(Fwd_A), 32'd0);
    check("rst_fwd_b", 32'(Fwd_B), 32'd0);

    // Plain register load, RegDst=1
    ID_Valid = 1'b1; ID_RD1 = 32'd10; ID_RD2 = 32'd15; ID_ALUSrc = 1'b0;
    ID_ALU_Control = 3'b010; ID_Rs = 5'd1; ID_Rt = 5'd2; ID_Rd = 5'd3;
    ID_RegDst = 1'b1; ID_RegWrite = 1'b1;
    tick();
    check("load_src1", Src1, 32'd10);
    check("load_src2", Src2, 32'd15);
    check("load_ctrl", 32'(ALU_Control), 32'h2);
    check("load_fwd_a", 32'(Fwd_A), 32'd0);
    check("load_fwd_b", 32'(Fwd_B), 32'd0);
    check("load_wreg_rd", 32'(EX_WriteReg), 32'd3);
    check("load_regwrite", 32'(EX_RegWrite), 32'd1);
    check("load_valid", 32'(EX_Valid), 32'd1);

    // Immediate operand, RegDst=0 selects Rt
    ID_ALUSrc = 1'b1; ID_SignImm = 32'hFFFF_FFFE; ID_RegDst = 1'b0;
    tick();
    check("imm_src2", Src2, 32'hFFFF_FFFE);
    check("imm_wdata", EX_WriteData, 32'd15);
    check("imm_wreg_rt", 32'(EX_WriteReg), 32'd2);

    // Forward priority on Rs=8
    ID_ALUSrc = 1'b0; ID_Rs = 5'd8; ID_RD1 = 32'd100;
    tick();
    MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd8; MEM_ALU_Result = 32'd25;
    WB_RegWrite = 1'b1;  WB_WriteReg = 5'd8;  WB_Result = 32'd7;
    #1;
    check("fwd_mem_sel", 32'(Fwd_A), 32'h2);
    check("fwd_mem_src1", Src1, 32'd25);
    MEM_RegWrite = 1'b0;
    #1;
    check("fwd_wb_sel", 32'(Fwd_A), 32'h1);
    check("fwd_wb_src1", Src1, 32'd7);

    // Register 0 is never forwarded
    MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd0; WB_WriteReg = 5'd0;
    ID_Rs = 5'd0; ID_RD1 = 32'd44;
    tick();
    check("r0_fwd_a", 32'(Fwd_A), 32'd0);
    check("r0_src1", Src1, 32'd44);

    // Bubble: no forwarding even when a writer matches Rs
    ID_Valid = 1'b0; ID_Rs = 5'd8; MEM_WriteReg = 5'd8;
    tick();
    check("bubble_valid", 32'(EX_Valid), 32'd0);
    check("bubble_fwd_a", 32'(Fwd_A), 32'd0);
    check("bubble_ctrl", 32'(ALU_Control), 32'h7);
    check("bubble_src1", Src1, 32'd0);

    // Stall refresh: Rt=9 forwarded from MEM with 5
    ID_Valid = 1'b1; ID_Rs = 5'd3; ID_Rt = 5'd9; ID_RD1 = 32'd3; ID_RD2 = 32'd1;
    ID_ALU_Control = 3'b100; WB_RegWrite = 1'b0;
    MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd9; MEM_ALU_Result = 32'd5;
    tick();
    Stall = 1'b1; ID_RD2 = 32'd77; ID_ALU_Control = 3'b001;
    #1;
    check("stall1_fwd_b", 32'(Fwd_B), 32'h2);
    check("stall1_src2", Src2, 32'd5);
    tick();
    MEM_RegWrite = 1'b0; WB_RegWrite = 1'b1; WB_WriteReg = 5'd9; WB_Result = 32'd5;
    MEM_ALU_Result = 32'd99;
    #1;
    check("stall2_fwd_b", 32'(Fwd_B), 32'd0);
    check("stall2_src2", Src2, 32'd5);
    check("stall2_ctrl_hold", 32'(ALU_Control), 32'h4);
    tick();
    WB_RegWrite = 1'b0; WB_Result = 32'd123;
    #1;
    check("stall3_fwd_b", 32'(Fwd_B), 32'd0);
    check("stall3_src2", Src2, 32'd5);
    check("stall3_wdata", EX_WriteData, 32'd5);
    tick();
    Stall = 1'b0; ID_RD1 = 32'd11; ID_RD2 = 32'd22; ID_Rt = 5'd4;
    tick();
    check("release_src1", Src1, 32'd11);
    check("release_src2", Src2, 32'd22);
    check("release_ctrl", 32'(ALU_Control), 32'h1);

    // Flush overrides Stall
    Flush = 1'b1; Stall = 1'b1;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    check("flush_valid", 32'(EX_Valid), 32'd0);
    check("flush_regwrite", 32'(EX_RegWrite), 32'd0);
    check("flush_ctrl", 32'(ALU_Control), 32'h7);
    check("flush_src1", Src1, 32'd0);

    // Reset in the middle of a stall discards the held instruction
    ID_RD1 = 32'd9; ID_RD2 = 32'd8; ID_ALU_Control = 3'b010; ID_RegWrite = 1'b1;
    tick();
    check("pre_rst_valid", 32'(EX_Valid), 32'd1);
    Stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(EX_Valid), 32'd0);
    check("mid_rst_regwrite", 32'(EX_RegWrite), 32'd0);
    check("mid_rst_ctrl", 32'(ALU_Control), 32'h7);
    check("mid_rst_src1", Src1, 32'd0);
    check("mid_rst_src2", Src2, 32'd0);
    check("mid_rst_wreg", 32'(EX_WriteReg), 32'd0);
    tick();
    check("mid_rst_hold_valid", 32'(EX_Valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
